// File: rtl/wb_interconnect.sv
// Single-master Wishbone interconnect that decodes the address to one of N_SLAVES ports.
// It also returns an error termination on a decode miss or when a slave stops responding.
module wb_interconnect #(
    parameter int                     N_SLAVES       = 4,
    parameter logic [32*N_SLAVES-1:0] SLAVE_BASE     = {32'h4000_0000, 32'h3000_0000,
                                                        32'h2000_0000, 32'h1000_0000},
    parameter logic [32*N_SLAVES-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
    parameter logic [31:0]            TIMEOUT_CYCLES = 32'd255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic                     m_we_i,
    input  logic [31:0]              m_adr_i,
    input  logic [3:0]               m_sel_i,
    input  logic [31:0]              m_dat_i,
    output logic [31:0]              m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_rty_o,
    output logic [N_SLAVES-1:0]      s_cyc_o,
    output logic [N_SLAVES-1:0]      s_stb_o,
    output logic [31:0]              s_adr_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_dat_o,
    output logic                     s_we_o,
    input  logic [32*N_SLAVES-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]      s_ack_i,
    input  logic [N_SLAVES-1:0]      s_err_i,
    input  logic [N_SLAVES-1:0]      s_rty_i,
    output logic                     err_irq_o,
    output logic [31:0]              err_adr_o
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] DECERR  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    logic [1:0]          state_r;
    logic [1:0]          state_nx_s;
    logic [IDX_W-1:0]    sel_r;
    logic [IDX_W-1:0]    sel_nx_s;
    logic [31:0]         cnt_r;
    logic [31:0]         cnt_nx_s;
    logic [31:0]         err_adr_r;

    logic                hit_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic [N_SLAVES-1:0] sel_oh_s;
    logic [31:0]         sl_dat_s;
    logic                sl_ack_s;
    logic                sl_err_s;
    logic                sl_rty_s;
    logic                busy_s;
    logic                err_st_s;
    logic                term_s;

    // Address decode; scanning from the top down lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((m_adr_i & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(k);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // One-hot of the latched target and AND-OR mux of its return path.
    always_comb begin
        sel_oh_s = '0;
        sl_dat_s = 32'h0000_0000;
        for (int k = 0; k < N_SLAVES; k++) begin
            sel_oh_s[k] = (sel_r == IDX_W'(k));
            sl_dat_s    = sl_dat_s | (s_dat_i[32*k +: 32] & {32{sel_oh_s[k]}});
        end
        sl_ack_s = |(s_ack_i & sel_oh_s);
        sl_err_s = |(s_err_i & sel_oh_s);
        sl_rty_s = |(s_rty_i & sel_oh_s);
    end

    assign busy_s   = (state_r == BUSY);
    assign err_st_s = (state_r == DECERR) || (state_r == TIMEOUT);
    assign term_s   = busy_s && (sl_ack_s || sl_err_s || sl_rty_s);

    // Next-state logic; a slave termination always takes priority over the timeout.
    always_comb begin
        state_nx_s = state_r;
        sel_nx_s   = sel_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (hit_s) begin
                        state_nx_s = BUSY;
                        sel_nx_s   = hit_idx_s;
                        cnt_nx_s   = 32'h0000_0000;
                    end else begin
                        state_nx_s = DECERR;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (term_s) begin
                    state_nx_s = IDLE;
                end else if (!m_cyc_i) begin
                    state_nx_s = IDLE;
                end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_r >= TIMEOUT_CYCLES)) begin
                    state_nx_s = TIMEOUT;
                end else begin
                    cnt_nx_s = cnt_r + 32'd1;
                end
            end
            DECERR:  state_nx_s = IDLE;
            TIMEOUT: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, target, counter and error-address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            cnt_r     <= 32'h0000_0000;
            err_adr_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            sel_r   <= sel_nx_s;
            cnt_r   <= cnt_nx_s;
            if (err_st_s) begin
                err_adr_r <= m_adr_i;
            end else begin
                err_adr_r <= err_adr_r;
            end
        end
    end

    assign s_adr_o = m_adr_i;
    assign s_sel_o = m_sel_i;
    assign s_dat_o = m_dat_i;
    assign s_we_o  = m_we_i;

    assign s_cyc_o = busy_s ? (sel_oh_s & {N_SLAVES{m_cyc_i}}) : '0;
    assign s_stb_o = busy_s ? (sel_oh_s & {N_SLAVES{m_stb_i}}) : '0;

    assign m_dat_o   = busy_s ? sl_dat_s : 32'h0000_0000;
    assign m_ack_o   = busy_s && sl_ack_s;
    assign m_rty_o   = busy_s && sl_rty_s;
    assign m_err_o   = (busy_s && sl_err_s) || err_st_s;
    assign err_irq_o = err_st_s;
    assign err_adr_o = err_adr_r;

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboard bench for wb_interconnect: directed transactions push expected master
// terminations; a negedge monitor pops and compares whenever one appears.
module tb_wb_interconnect;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        irq;
        logic [31:0] dat;
    } resp_t;

    logic         clk_i;
    logic         rst_ni;
    logic         m_cyc_i, m_stb_i, m_we_i;
    logic [31:0]  m_adr_i, m_dat_i;
    logic [3:0]   m_sel_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o, m_err_o, m_rty_o;
    logic [3:0]   s_cyc_o, s_stb_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i, s_err_i, s_rty_i;
    logic         err_irq_o;
    logic [31:0]  err_adr_o;

    int    tests = 0;
    int    fails = 0;
    resp_t exp_q[$];
    resp_t mon_e;

    wb_interconnect #(
        .N_SLAVES(4),
        .TIMEOUT_CYCLES(32'd4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
        .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .err_irq_o(err_irq_o), .err_adr_o(err_adr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_adr_i = adr;
        m_dat_i = dat;
        m_sel_i = 4'hF;
    endtask

    task automatic idle_bus();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
        s_ack_i = 4'b0000;
        s_err_i = 4'b0000;
        s_rty_i = 4'b0000;
    endtask

    task automatic push(input logic ack, input logic err, input logic rty,
                        input logic irq, input logic [31:0] dat);
        resp_t r;
        r.ack = ack; r.err = err; r.rty = rty; r.irq = irq; r.dat = dat;
        exp_q.push_back(r);
    endtask

    // Monitor: every master termination or error pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni && (m_ack_o || m_err_o || m_rty_o || err_irq_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_term", {28'h0, m_ack_o, m_err_o, m_rty_o, err_irq_o}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("term_ack", {31'h0, m_ack_o}, {31'h0, mon_e.ack});
                chk("term_err", {31'h0, m_err_o}, {31'h0, mon_e.err});
                chk("term_rty", {31'h0, m_rty_o}, {31'h0, mon_e.rty});
                chk("term_irq", {31'h0, err_irq_o}, {31'h0, mon_e.irq});
                chk("term_dat", m_dat_o, mon_e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_ni  = 1'b0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b1;
        m_adr_i = 32'h0000_1234; m_sel_i = 4'hA; m_dat_i = 32'h0000_0055;
        s_dat_i = 128'h0;
        s_ack_i = 4'b0000; s_err_i = 4'b0000; s_rty_i = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk_i);
        at_neg();
        chk("rst_s_cyc", {28'h0, s_cyc_o}, 32'h0);
        chk("rst_s_stb", {28'h0, s_stb_o}, 32'h0);
        chk("rst_m_dat", m_dat_o, 32'h0);
        chk("rst_term", {29'h0, m_ack_o, m_err_o, m_rty_o}, 32'h0);
        chk("rst_irq", {31'h0, err_irq_o}, 32'h0);
        chk("rst_err_adr", err_adr_o, 32'h0);
        chk("rst_pass_adr", s_adr_o, 32'h0000_1234);
        chk("rst_pass_sel", {28'h0, s_sel_o}, 32'h0000_000A);
        chk("rst_pass_dat", s_dat_o, 32'h0000_0055);
        chk("rst_pass_we", {31'h0, s_we_o}, 32'h1);
        #1;
        rst_ni = 1'b1;
        idle_bus();
        cyc_edge();

        // Read slave 0, ack two cycles after strobe
        req(32'h1000_0004, 1'b0, 32'h0);
        s_dat_i[31:0] = 32'hDEAD_BEEF;
        at_neg();
        chk("rd_idle_stb", {28'h0, s_stb_o}, 32'h0);
        cyc_edge();
        at_neg();
        chk("rd_stb", {28'h0, s_stb_o}, 32'h0000_0001);
        chk("rd_cyc", {28'h0, s_cyc_o}, 32'h0000_0001);
        cyc_edge();
        cyc_edge();
        s_ack_i = 4'b0001;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc_edge();
        idle_bus();
        at_neg();
        chk("rd_ack_one_cycle", {31'h0, m_ack_o}, 32'h0);

        // Write slave 3, same-cycle ack
        req(32'h4000_0000, 1'b1, 32'h0000_0003);
        s_dat_i[127:96] = 32'hCAFE_0003;
        at_neg();
        chk("wr_s_dat", s_dat_o, 32'h0000_0003);
        chk("wr_s_we", {31'h0, s_we_o}, 32'h1);
        cyc_edge();
        s_ack_i = 4'b1000;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0003);
        at_neg();
        chk("wr_stb", {28'h0, s_stb_o}, 32'h0000_0008);
        cyc_edge();
        idle_bus();

        // Decode error
        req(32'h8000_0000, 1'b0, 32'h0);
        at_neg();
        chk("dec_stb_t", {28'h0, s_stb_o}, 32'h0);
        cyc_edge();
        push(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        at_neg();
        chk("dec_stb_t1", {28'h0, s_stb_o}, 32'h0);
        cyc_edge();
        chk("dec_err_adr", err_adr_o, 32'h8000_0000);
        idle_bus();
        at_neg();
        chk("dec_err_one_cycle", {31'h0, m_err_o}, 32'h0);

        // Timeout on slave 1: error at t+6
        req(32'h2000_0010, 1'b0, 32'h0);
        cyc_edge();
        at_neg();
        chk("tmo_cyc_busy", {28'h0, s_cyc_o}, 32'h0000_0002);
        repeat (5) cyc_edge();
        push(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        at_neg();
        chk("tmo_cyc_drop", {28'h0, s_cyc_o}, 32'h0);
        cyc_edge();
        chk("tmo_err_adr", err_adr_o, 32'h2000_0010);
        idle_bus();

        // Slave 2 acks in the cycle the count reaches the limit
        req(32'h3000_0000, 1'b0, 32'h0);
        s_dat_i[95:64] = 32'h0000_0A05;
        cyc_edge();
        at_neg();
        chk("race_stb", {28'h0, s_stb_o}, 32'h0000_0004);
        repeat (4) cyc_edge();
        s_ack_i = 4'b0100;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0A05);
        cyc_edge();
        idle_bus();
        at_neg();
        chk("race_no_err", {31'h0, m_err_o}, 32'h0);
        chk("race_no_irq", {31'h0, err_irq_o}, 32'h0);
        chk("race_err_adr_kept", err_adr_o, 32'h2000_0010);

        // Foreign terminations ignored; multiple terminations pass together
        req(32'h1000_0000, 1'b0, 32'h0);
        s_dat_i[31:0] = 32'h6666_0006;
        cyc_edge();
        s_ack_i = 4'b0010; s_err_i = 4'b0100; s_rty_i = 4'b1000;
        at_neg();
        chk("foreign_ignored", {29'h0, m_ack_o, m_err_o, m_rty_o}, 32'h0);
        cyc_edge();
        s_ack_i = 4'b0000; s_err_i = 4'b0001; s_rty_i = 4'b0001;
        push(1'b0, 1'b1, 1'b1, 1'b0, 32'h6666_0006);
        cyc_edge();
        idle_bus();

        // Master abandons the cycle: back to idle, no timeout error later
        req(32'h4000_0100, 1'b0, 32'h0);
        cyc_edge();
        at_neg();
        chk("abort_cyc_busy", {28'h0, s_cyc_o}, 32'h0000_0008);
        cyc_edge();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        at_neg();
        chk("abort_cyc_drop", {28'h0, s_cyc_o}, 32'h0);
        repeat (7) cyc_edge();
        chk("abort_err_adr_kept", err_adr_o, 32'h2000_0010);

        // Reset during BUSY, then a normal access right after release
        req(32'h1000_0000, 1'b0, 32'h0);
        s_dat_i[31:0] = 32'h0000_0041;
        cyc_edge();
        at_neg();
        chk("mid_rst_cyc_busy", {28'h0, s_cyc_o}, 32'h0000_0001);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_cyc_drop", {28'h0, s_cyc_o}, 32'h0);
        chk("mid_rst_stb_drop", {28'h0, s_stb_o}, 32'h0);
        at_neg();
        chk("mid_rst_no_err", {30'h0, m_err_o, err_irq_o}, 32'h0);
        chk("mid_rst_err_adr", err_adr_o, 32'h0);
        #1;
        rst_ni = 1'b1;
        cyc_edge();
        at_neg();
        chk("post_rst_stb", {28'h0, s_stb_o}, 32'h0000_0001);
        cyc_edge();
        s_ack_i = 4'b0001;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0041);
        cyc_edge();
        idle_bus();

        repeat (3) cyc_edge();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
